// File: rtl/gray_stage.sv
// -----------------------------------------------------------------------------
// gray_stage
//
// Purpose:
//   One grayscale pass over a square WIDTH x WIDTH RGB image that lives in an
//   external memory. The image is walked row-major. Each pixel takes two
//   cycles. In READ the current pixel is presented on in_pix
//   (combinational read). In WRITE the pixel is written back as
//   {R=0, G=gray, B=0}. When the last pixel has been written, done is raised.
//   done stays high until start is released.
//
//   gray = (max(R,G,B) + min(R,G,B)) >> 1, computed at CH_W+1 bits so the
//   sum cannot overflow.
//
// Handshake:
//   start is a level request. It is sampled only in IDLE (to begin a pass) and
//   in DONE (start=0 returns to IDLE). While a pass runs, start is ignored.
//   Only rst_n can stop a pass. out_we is a one-cycle strobe. The memory
//   captures out_pix at row/col on the rising edge where out_we is high.
//   Nothing is rolled back on reset: pixels already written stay written.
//
// Ports:
//   clk      in   1        rising-edge clock
//   rst_n    in   1        asynchronous active-low reset
//   start    in   1        level request to process the image
//   in_pix   in   3*CH_W   memory read data at row/col, {R,G,B}
//   row      out  ADDR_W   pixel row address
//   col      out  ADDR_W   pixel column address
//   out_we   out  1        write strobe for out_pix at row/col
//   out_pix  out  3*CH_W   write data {0, gray, 0}
//   done     out  1        pass complete
// -----------------------------------------------------------------------------
module gray_stage #(
    parameter int WIDTH  = 64,
    parameter int ADDR_W = 6,
    parameter int CH_W   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [3*CH_W-1:0]   in_pix,
    output logic [ADDR_W-1:0]   row,
    output logic [ADDR_W-1:0]   col,
    output logic                out_we,
    output logic [3*CH_W-1:0]   out_pix,
    output logic                done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WIDTH - 1);

    state_t state;

    // Channel split of the pixel being read.
    logic [CH_W-1:0] ch_r;
    logic [CH_W-1:0] ch_g;
    logic [CH_W-1:0] ch_b;
    logic [CH_W-1:0] ch_max;
    logic [CH_W-1:0] ch_min;
    logic [CH_W:0]   ch_sum;
    logic [CH_W-1:0] gray;

    assign ch_r = in_pix[3*CH_W-1:2*CH_W];
    assign ch_g = in_pix[2*CH_W-1:CH_W];
    assign ch_b = in_pix[CH_W-1:0];

    always_comb begin
        ch_max = ch_r;
        if (ch_g > ch_max) ch_max = ch_g;
        if (ch_b > ch_max) ch_max = ch_b;

        ch_min = ch_r;
        if (ch_g < ch_min) ch_min = ch_g;
        if (ch_b < ch_min) ch_min = ch_b;

        // Widen both operands by one bit so the carry is kept.
        // Then drop the LSB to get the floor of the average.
        ch_sum = {1'b0, ch_max} + {1'b0, ch_min};
        gray   = ch_sum[CH_W:1];
    end

    // Single FSM process. Every output is a register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            row     <= '0;
            col     <= '0;
            out_we  <= 1'b0;
            out_pix <= '0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    row    <= '0;
                    col    <= '0;
                    out_we <= 1'b0;
                    done   <= 1'b0;
                    if (start) state <= READ;
                end

                READ: begin
                    out_pix <= {{CH_W{1'b0}}, gray, {CH_W{1'b0}}};
                    out_we  <= 1'b1;
                    state   <= WRITE;
                end

                WRITE: begin
                    out_we <= 1'b0;
                    if (row == LAST && col == LAST) begin
                        // Last pixel written. The address stays put; no
                        // further pixel exists.
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        if (col == LAST) begin
                            col <= '0;
                            row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                        state <= READ;
                    end
                end

                DONE: begin
                    out_we <= 1'b0;
                    if (!start) begin
                        done  <= 1'b0;
                        row   <= '0;
                        col   <= '0;
                        state <= IDLE;
                    end
                end

                default: begin
                    state  <= IDLE;
                    out_we <= 1'b0;
                    done   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gray_stage.sv
// -----------------------------------------------------------------------------
// tb_gray_stage
//
// Bench for gray_stage at WIDTH=4. The image memory is a 16-entry array with
// a combinational read and a write on every edge where out_we is high.
// Before each pass the expected write sequence {row, col, pixel} is pushed to
// a queue. A negedge monitor pops one entry for each out_we strobe.
// -----------------------------------------------------------------------------
module tb_gray_stage;

    localparam int W      = 4;
    localparam int AW     = 2;
    localparam int CW     = 8;
    localparam int NPIX   = W * W;
    localparam int PW     = 3 * CW;
    localparam int BUDGET = 200;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          start;
    logic [PW-1:0] in_pix;
    logic [AW-1:0] row;
    logic [AW-1:0] col;
    logic          out_we;
    logic [PW-1:0] out_pix;
    logic          done;

    gray_stage #(.WIDTH(W), .ADDR_W(AW), .CH_W(CW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .in_pix  (in_pix),
        .row     (row),
        .col     (col),
        .out_we  (out_we),
        .out_pix (out_pix),
        .done    (done)
    );

    // ---------------- memory model ----------------
    logic [PW-1:0] mem     [NPIX];
    logic [PW-1:0] img     [NPIX];
    logic [PW-1:0] exp_img [NPIX];
    logic          load_req = 1'b0;

    assign in_pix = mem[{row, col}];

    always @(posedge clk) begin
        if (load_req) mem <= img;
        else if (out_we) mem[{row, col}] <= out_pix;
    end

    // ---------------- scoreboard ----------------
    logic [2*AW+PW-1:0] exp_q[$];
    int tests = 0;
    int fails = 0;
    int writes = 0;

    function automatic logic [PW-1:0] ref_gray(input logic [PW-1:0] p);
        int c [3];
        int mx, mn;
        c[0] = int'(p[23:16]);
        c[1] = int'(p[15:8]);
        c[2] = int'(p[7:0]);
        mx = c[0];
        mn = c[0];
        for (int i = 1; i < 3; i++) begin
            if (c[i] > mx) mx = c[i];
            if (c[i] < mn) mn = c[i];
        end
        return {8'h00, 8'((mx + mn) / 2), 8'h00};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Queue the expected writes of one full pass, taken from the memory
    // contents at this moment.
    task automatic push_frame();
        for (int a = 0; a < NPIX; a++) begin
            exp_img[a] = ref_gray(mem[a]);
            exp_q.push_back({AW'(a / W), AW'(a % W), exp_img[a]});
        end
    endtask

    // Write monitor: every strobe must match the head of the queue.
    always @(negedge clk) begin
        if (out_we) begin
            logic [2*AW+PW-1:0] e;
            writes++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(writes), 32'(0));
            end else begin
                e = exp_q.pop_front();
                check("write_addr", 32'({row, col}), 32'(e[2*AW+PW-1:PW]));
                check("write_data", 32'(out_pix), 32'(e[PW-1:0]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic load_image();
        @(negedge clk);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    // Start a pass. Return the number of edges after E0 until done is seen.
    // If toggle is set, start is scrambled on every cycle while the pass runs.
    task automatic run_pass(input bit toggle, output int edges);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);          // E0
        edges = 0;
        for (int i = 1; i <= BUDGET; i++) begin
            @(posedge clk);
            edges = i;
            #1;
            if (i == 8) check("wrap_addr", 32'({row, col, out_we}), {27'd0, 2'd1, 2'd0, 1'b0});
            if (done) break;
            if (toggle) start = 1'(($urandom_range(0, 1)));
        end
        start = 1'b1;
        check("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic check_mem(input string tag);
        for (int a = 0; a < NPIX; a++) check(tag, 32'(mem[a]), 32'(exp_img[a]));
    endtask

    task automatic release_start();
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check("idle_after_drop", 32'({done, row, col, out_we}), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int edges;
        int w0;
        start = 1'b0;
        img[0] = 24'hC86432;
        img[1] = 24'hFFFFFF;
        img[2] = 24'hFF0001;
        img[3] = 24'h000000;
        for (int a = 4; a < NPIX; a++) img[a] = PW'($urandom_range(0, 24'hFFFFFF));

        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 32'({row, col, out_we, done}), 32'd0);
        check("reset_pix", 32'(out_pix), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        load_image();

        // Full frame pass with pixel math corner values.
        push_frame();
        w0 = writes;
        run_pass(1'b0, edges);
        check("done_edge", 32'(edges), 32'(2 * NPIX));
        @(negedge clk);
        check("write_count", 32'(writes - w0), 32'(NPIX));
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("math_c86432", 32'(mem[0]), 32'h007D00);
        check("math_ffffff", 32'(mem[1]), 32'h00FF00);
        check("math_ff0001", 32'(mem[2]), 32'h007F00);
        check("math_000000", 32'(mem[3]), 32'h000000);
        check_mem("frame1_mem");

        // Holding start after done: no writes, and done stays high.
        w0 = writes;
        repeat (5) begin
            @(posedge clk);
            #1;
            check("done_hold", 32'({done, out_we}), 32'b10);
        end
        check("hold_no_writes", 32'(writes - w0), 32'd0);
        release_start();

        // Second pass runs on the gray image. This time start toggles
        // during the pass.
        push_frame();
        w0 = writes;
        run_pass(1'b1, edges);
        check("done_edge_toggle", 32'(edges), 32'(2 * NPIX));
        @(negedge clk);
        check("write_count_toggle", 32'(writes - w0), 32'(NPIX));
        check_mem("frame2_mem");
        release_start();

        // Reset mid-pass during the WRITE of pixel 5.
        for (int a = 0; a < NPIX; a++) img[a] = PW'($urandom_range(1, 24'hFFFFFF));
        load_image();
        push_frame();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);          // E0
        repeat (11) @(posedge clk);
        #2;
        check("pix5_write", 32'({out_we, row, col}), {27'd0, 1'b1, 2'd1, 2'd1});
        rst_n = 1'b0;
        #1;
        check("async_reset_ctl", 32'({row, col, out_we, done}), 32'd0);
        check("async_reset_pix", 32'(out_pix), 32'd0);
        exp_q.delete();
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int a = 0; a < NPIX; a++)
            check("partial_mem", 32'(mem[a]), 32'((a < 5) ? exp_img[a] : img[a]));

        // A fresh start converts the whole (partly converted) frame.
        push_frame();
        w0 = writes;
        run_pass(1'b0, edges);
        check("done_edge_restart", 32'(edges), 32'(2 * NPIX));
        @(negedge clk);
        check("write_count_restart", 32'(writes - w0), 32'(NPIX));
        check_mem("restart_mem");
        release_start();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
